exec_stage_pipe: RTL and testbench

//  Parametrised execute stage with an EX/MEM output register: extender, ALU-source mux, ALU, and iterative multiply/divide unit.

---
 rtl/exec_pkg.sv | 35 +++
 rtl/muldiv_iter.sv | 85 ++++++++
 rtl/exec_stage_pipe.sv | 157 +++++++++++++++
 tb/tb_exec_stage_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU op codes, mul/div op codes,
// mul/div FSM state encoding and the RegWr control bit index.
package exec_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;
    localparam logic [3:0] ALU_MFHI = 4'd11;
    localparam logic [3:0] ALU_MFLO = 4'd12;

    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;

    localparam int REGWR_BIT = 0;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Code 11 is reserved and behaves as a plain ALU instruction.
    function automatic logic is_md(input logic [1:0] op);
        return (op == MD_MULTU) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one step per cycle.
// Result stays in DONE until ack; abort returns to IDLE from any state.
module muldiv_iter
    import exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              ack,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    md_state_e state, state_nx;
    logic [CNT_W-1:0] count;
    logic is_div;
    // hi_p/lo_p: {acc, multiplier} for MULTU, {remainder, quotient} for DIVU
    logic [DATA_W-1:0] hi_p, lo_p, oper;

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   r_sh;
    logic              ge;
    logic [DATA_W-1:0] rem_nx;

    assign sum    = {1'b0, hi_p} + (lo_p[0] ? {1'b0, oper} : '0);
    assign r_sh   = {hi_p, lo_p[DATA_W-1]};
    assign ge     = r_sh >= {1'b0, oper};
    assign rem_nx = ge ? DATA_W'(r_sh - {1'b0, oper}) : r_sh[DATA_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            MD_IDLE: if (start) state_nx = MD_BUSY;
            MD_BUSY: if (count == CNT_W'(1)) state_nx = MD_DONE;
            MD_DONE: if (ack) state_nx = MD_IDLE;
            default: state_nx = MD_IDLE;
        endcase
        if (abort) state_nx = MD_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            is_div <= 1'b0;
            hi_p   <= '0;
            lo_p   <= '0;
            oper   <= '0;
        end else if (state == MD_IDLE && start) begin
            count  <= CNT_W'(DATA_W);
            is_div <= (op == MD_DIVU);
            hi_p   <= '0;
            lo_p   <= (op == MD_DIVU) ? a : b;
            oper   <= (op == MD_DIVU) ? b : a;
        end else if (state == MD_BUSY) begin
            count <= count - CNT_W'(1);
            if (is_div) begin
                hi_p <= rem_nx;
                lo_p <= {lo_p[DATA_W-2:0], ge};
            end else begin
                hi_p <= sum[DATA_W:1];
                lo_p <= {sum[0], lo_p[DATA_W-1:1]};
            end
        end
    end

    assign busy = (state == MD_BUSY);
    assign done = (state == MD_DONE);
    assign hi   = hi_p;
    assign lo   = lo_p;

endmodule

// File: rtl/exec_stage_pipe.sv
// Execute stage with EX/MEM register, HI/LO and iterative mul/div.
// Define EXEC_FWD_EN to add the operand bypass muxes and their ports.
module exec_stage_pipe
    import exec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int CTRL_W = 10,
    parameter int RA_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              stall_in,
    input  logic              flush,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [3:0]        alu_ctrl,
    input  logic [1:0]        md_op,
    input  logic              alu_src,
    input  logic              ext_op,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] bus_a,
    input  logic [DATA_W-1:0] bus_b,
    input  logic [RA_W-1:0]   rd_in,
`ifdef EXEC_FWD_EN
    input  logic [1:0]        fwd_a_sel,
    input  logic [1:0]        fwd_b_sel,
    input  logic [DATA_W-1:0] mem_fwd,
    input  logic [DATA_W-1:0] wb_fwd,
`endif
    output logic              out_valid,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] store_data,
    output logic              zero_out,
    output logic [RA_W-1:0]   rd_out
);
    localparam int SH_W = $clog2(DATA_W);

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] sd;
        logic              zero;
        logic [RA_W-1:0]   rd;
    } exmem_t;

    exmem_t exmem_q, exmem_nx, md_q;
    logic [DATA_W-1:0] opa, opb, ext_imm, alu_b, alu_res, hi_q, lo_q, md_hi, md_lo;
    logic [CTRL_W-1:0] ctrl_md;
    logic [SH_W-1:0] sh;
    logic accept, md_start, md_busy, md_done;

`ifdef EXEC_FWD_EN
    always_comb begin
        case (fwd_a_sel)
            2'b01:   opa = mem_fwd;
            2'b10:   opa = wb_fwd;
            default: opa = bus_a;
        endcase
        case (fwd_b_sel)
            2'b01:   opb = mem_fwd;
            2'b10:   opb = wb_fwd;
            default: opb = bus_b;
        endcase
    end
`else
    assign opa = bus_a;
    assign opb = bus_b;
`endif

    assign ext_imm = ext_op ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                            : {{(DATA_W-IMM_W){1'b0}}, imm};
    assign alu_b   = alu_src ? ext_imm : opb;
    assign sh      = opa[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_res = opa + alu_b;
            ALU_SUB:  alu_res = opa - alu_b;
            ALU_AND:  alu_res = opa & alu_b;
            ALU_OR:   alu_res = opa | alu_b;
            ALU_XOR:  alu_res = opa ^ alu_b;
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(opa) < $signed(alu_b)};
            ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, opa < alu_b};
            ALU_SLL:  alu_res = alu_b << sh;
            ALU_SRL:  alu_res = alu_b >> sh;
            ALU_SRA:  alu_res = $signed(alu_b) >>> sh;
            ALU_LUI:  alu_res = alu_b << IMM_W;
            ALU_MFHI: alu_res = hi_q;
            ALU_MFLO: alu_res = lo_q;
            default:  alu_res = '0;
        endcase
    end

    assign in_ready = !md_busy && !md_done && !stall_in && !flush;
    assign accept   = in_valid && in_ready;
    assign md_start = accept && is_md(md_op);

    muldiv_iter #(.DATA_W(DATA_W)) u_muldiv (
        .clock (clock),
        .reset (reset),
        .start (md_start),
        .abort (flush),
        .ack   (!stall_in),
        .op    (md_op),
        .a     (opa),
        .b     (opb),
        .busy  (md_busy),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    // Mul/div retires without a register write-back; only HI/LO change.
    always_comb begin
        ctrl_md = ctrl_in;
        ctrl_md[REGWR_BIT] = 1'b0;
    end

    always_comb begin
        exmem_nx = '0;
        if (flush)                         exmem_nx = '0;
        else if (stall_in)                 exmem_nx = exmem_q;
        else if (md_done)                  exmem_nx = md_q;
        else if (accept && !is_md(md_op))  exmem_nx = '{valid: 1'b1, ctrl: ctrl_in, alu: alu_res,
                                                       sd: opb, zero: (alu_res == '0), rd: rd_in};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            exmem_q <= '0;
            md_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            exmem_q <= exmem_nx;
            if (md_start)
                md_q <= '{valid: 1'b1, ctrl: ctrl_md, alu: '0, sd: opb, zero: 1'b1, rd: rd_in};
            if (md_done && !stall_in && !flush) begin
                hi_q <= md_hi;
                lo_q <= md_lo;
            end
        end
    end

    assign out_valid  = exmem_q.valid;
    assign ctrl_out   = exmem_q.ctrl;
    assign alu_out    = exmem_q.alu;
    assign store_data = exmem_q.sd;
    assign zero_out   = exmem_q.zero;
    assign rd_out     = exmem_q.rd;

endmodule

// File: tb/tb_exec_stage_pipe.sv
// Bench for exec_stage_pipe: directed checks with literal expectations, then
// randomized traffic against a transaction-level model of the stage.
module tb_exec_stage_pipe;
    import exec_pkg::*;

    localparam int W  = 32;
    localparam int IW = 16;
    localparam int CW = 10;
    localparam int RW = 5;

    logic          clock = 1'b0;
    logic          reset, in_valid, in_ready, stall_in, flush, alu_src, ext_op;
    logic [CW-1:0] ctrl_in, ctrl_out;
    logic [3:0]    alu_ctrl;
    logic [1:0]    md_op;
    logic [IW-1:0] imm;
    logic [W-1:0]  bus_a, bus_b, alu_out, store_data;
    logic [RW-1:0] rd_in, rd_out;
    logic          out_valid, zero_out;
`ifdef EXEC_FWD_EN
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [W-1:0]  mem_fwd, wb_fwd;
`endif

    always #5 clock = ~clock;

    exec_stage_pipe #(.DATA_W(W), .IMM_W(IW), .CTRL_W(CW), .RA_W(RW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .stall_in(stall_in), .flush(flush), .ctrl_in(ctrl_in), .alu_ctrl(alu_ctrl),
        .md_op(md_op), .alu_src(alu_src), .ext_op(ext_op), .imm(imm),
        .bus_a(bus_a), .bus_b(bus_b), .rd_in(rd_in),
`ifdef EXEC_FWD_EN
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
`endif
        .out_valid(out_valid), .ctrl_out(ctrl_out), .alu_out(alu_out),
        .store_data(store_data), .zero_out(zero_out), .rd_out(rd_out)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state: expected EX/MEM entry, architectural HI/LO, pending mul/div
    logic          e_valid, e_zero;
    logic [CW-1:0] e_ctrl, p_ctrl;
    logic [W-1:0]  e_alu, e_sd, m_hi, m_lo, p_hi, p_lo, p_sd;
    logic [RW-1:0] e_rd, p_rd;
    bit            m_pend;
    int            m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] eff_a();
`ifdef EXEC_FWD_EN
        if (fwd_a_sel == 2'b01) return mem_fwd;
        if (fwd_a_sel == 2'b10) return wb_fwd;
`endif
        return bus_a;
    endfunction

    function automatic logic [W-1:0] eff_b();
`ifdef EXEC_FWD_EN
        if (fwd_b_sel == 2'b01) return mem_fwd;
        if (fwd_b_sel == 2'b10) return wb_fwd;
`endif
        return bus_b;
    endfunction

    function automatic logic [W-1:0] alu_model(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        int s;
        s = int'(a % W);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
            ALU_SLTU: return (a < b) ? 1 : 0;
            ALU_SLL:  return b << s;
            ALU_SRL:  return b >> s;
            ALU_SRA:  return W'($signed(b) >>> s);
            ALU_LUI:  return b << IW;
            ALU_MFHI: return m_hi;
            ALU_MFLO: return m_lo;
            default:  return '0;
        endcase
    endfunction

    task automatic model_step();
        logic [W-1:0] a, b, opnd;
        logic [2*W-1:0] prod;
        if (reset) begin
            e_valid = 0; e_alu = 0; m_hi = 0; m_lo = 0; m_pend = 0; m_cnt = 0;
        end else if (flush) begin
            e_valid = 0; m_pend = 0;
        end else if (stall_in) begin
            if (m_pend && m_cnt > 0) m_cnt--;
        end else if (m_pend && m_cnt == 0) begin
            e_valid = 1; e_ctrl = p_ctrl; e_alu = 0; e_sd = p_sd; e_zero = 1; e_rd = p_rd;
            m_hi = p_hi; m_lo = p_lo; m_pend = 0;
        end else if (m_pend) begin
            m_cnt--; e_valid = 0;
        end else if (in_valid) begin
            a = eff_a(); b = eff_b();
            if (md_op == MD_MULTU || md_op == MD_DIVU) begin
                if (md_op == MD_MULTU) begin
                    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                    p_hi = prod[2*W-1:W]; p_lo = prod[W-1:0];
                end else if (b == 0) begin
                    p_lo = '1; p_hi = a;
                end else begin
                    p_lo = a / b; p_hi = a % b;
                end
                p_ctrl = ctrl_in & ~CW'(1); p_sd = b; p_rd = rd_in;
                m_pend = 1; m_cnt = W; e_valid = 0;
            end else begin
                opnd = alu_src ? (ext_op ? {{(W-IW){imm[IW-1]}}, imm} : {{(W-IW){1'b0}}, imm}) : b;
                e_alu = alu_model(alu_ctrl, a, opnd);
                e_valid = 1; e_ctrl = ctrl_in; e_sd = b; e_zero = (e_alu == 0); e_rd = rd_in;
            end
        end else begin
            e_valid = 0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_step();
    endtask

    task automatic op(input logic [3:0] ac, input logic [1:0] md, input logic src,
                      input logic ext, input logic [IW-1:0] im, input logic [W-1:0] a,
                      input logic [W-1:0] b);
        in_valid = 1; alu_ctrl = ac; md_op = md; alu_src = src; ext_op = ext; imm = im;
        bus_a = a; bus_b = b; rd_in = 5'd9; ctrl_in = 10'h3FF;
        tick();
        in_valid = 0;
    endtask

    // Start a mul/div and wait for it to retire; returns cycles in_ready was low.
    task automatic run_md(input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int n);
        op(ALU_ADD, md, 1'b0, 1'b0, '0, a, b);
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            n++;
            tick();
        end
        if (n >= 100) check("md_timeout", 64'(n), 64'(W + 1));
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("out_valid", out_valid, e_valid);
            check("in_ready", in_ready, !m_pend && !stall_in && !flush);
            if (e_valid) begin
                check("ctrl_out", ctrl_out, e_ctrl);
                check("alu_out", alu_out, e_alu);
                check("store_data", store_data, e_sd);
                check("zero_out", zero_out, e_zero);
                check("rd_out", rd_out, e_rd);
            end
        end
    end

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return W'($urandom_range(0, 40));
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int r;
        reset = 1; in_valid = 0; stall_in = 0; flush = 0; alu_src = 0; ext_op = 0;
        ctrl_in = 0; alu_ctrl = 0; md_op = 0; imm = 0; bus_a = 0; bus_b = 0; rd_in = 0;
`ifdef EXEC_FWD_EN
        fwd_a_sel = 0; fwd_b_sel = 0; mem_fwd = 0; wb_fwd = 0;
`endif
        tick();
        chk_en = 1;
        tick();
        reset = 0;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_out", alu_out, 0);
        check("rst_in_ready", in_ready, 1);

        op(ALU_ADD, 2'b00, 1'b1, 1'b1, 16'hFFFF, 5, 0);
        check("add_alu", alu_out, 4);
        check("add_zero", zero_out, 0);
        op(ALU_SUB, 2'b00, 1'b0, 1'b0, 0, 7, 7);
        check("sub_zero", zero_out, 1);

        run_md(MD_MULTU, 32'hFFFF_FFFF, 2, n);
        check("mul_busy_cycles", 64'(n), 33);
        check("mul_out_valid", out_valid, 1);
        check("mul_alu_zero", alu_out, 0);
        check("mul_regwr_clr", ctrl_out, 10'h3FE);
        op(ALU_MFHI, 2'b00, 1'b0, 1'b0, 0, 0, 0);
        check("mul_hi", alu_out, 1);
        op(ALU_MFLO, 2'b00, 1'b0, 1'b0, 0, 0, 0);
        check("mul_lo", alu_out, 32'hFFFF_FFFE);

        run_md(MD_DIVU, 100, 7, n);
        op(ALU_MFLO, 2'b00, 1'b0, 1'b0, 0, 0, 0);
        check("div_lo", alu_out, 14);
        op(ALU_MFHI, 2'b00, 1'b0, 1'b0, 0, 0, 0);
        check("div_hi", alu_out, 2);
        run_md(MD_DIVU, 9, 0, n);
        op(ALU_MFLO, 2'b00, 1'b0, 1'b0, 0, 0, 0);
        check("div0_lo", alu_out, 32'hFFFF_FFFF);
        op(ALU_MFHI, 2'b00, 1'b0, 1'b0, 0, 0, 0);
        check("div0_hi", alu_out, 9);

        // Stall held across DONE
        op(ALU_ADD, MD_MULTU, 1'b0, 1'b0, 0, 3, 5);
        for (int i = 0; i < W; i++) tick();
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_valid", out_valid, 0);
        end
        stall_in = 0;
        tick();
        check("stall_release_valid", out_valid, 1);
        op(ALU_MFLO, 2'b00, 1'b0, 1'b0, 0, 0, 0);
        check("stall_lo", alu_out, 15);

        // Flush mid-BUSY leaves HI/LO untouched
        op(ALU_ADD, MD_MULTU, 1'b0, 1'b0, 0, 7, 9);
        for (int i = 0; i < 10; i++) tick();
        flush = 1;
        tick();
        flush = 0;
        #1;
        check("flush_ready", in_ready, 1);
        check("flush_valid", out_valid, 0);
        op(ALU_MFLO, 2'b00, 1'b0, 1'b0, 0, 0, 0);
        check("flush_lo_kept", alu_out, 15);
        op(ALU_MFHI, 2'b00, 1'b0, 1'b0, 0, 0, 0);
        check("flush_hi_kept", alu_out, 0);

`ifdef EXEC_FWD_EN
        fwd_a_sel = 2'b01; mem_fwd = 40;
        op(ALU_ADD, 2'b00, 1'b0, 1'b0, 0, 1000, 2);
        check("fwd_a_add", alu_out, 42);
        fwd_a_sel = 2'b00; fwd_b_sel = 2'b10; wb_fwd = 32'hCAFE_0001;
        op(ALU_ADD, 2'b00, 1'b1, 1'b0, 16'h0010, 8, 5);
        check("fwd_b_store", store_data, 32'hCAFE_0001);
        fwd_b_sel = 2'b00;
`endif

        for (int c = 0; c < 4000; c++) begin
            reset    = ($urandom_range(0, 199) == 0);
            stall_in = ($urandom_range(0, 99) < 15);
            flush    = ($urandom_range(0, 99) < 3);
            in_valid = ($urandom_range(0, 99) < 70);
            r = $urandom_range(0, 99);
            md_op    = (r < 6) ? MD_MULTU : (r < 12) ? MD_DIVU : (r < 15) ? 2'b11 : 2'b00;
            alu_ctrl = 4'($urandom_range(0, 15));
            alu_src  = 1'($urandom);
            ext_op   = 1'($urandom);
            imm      = IW'($urandom);
            bus_a    = rnd_val();
            bus_b    = rnd_val();
            rd_in    = RW'($urandom);
            ctrl_in  = CW'($urandom);
`ifdef EXEC_FWD_EN
            fwd_a_sel = 2'($urandom); fwd_b_sel = 2'($urandom);
            mem_fwd = rnd_val(); wb_fwd = rnd_val();
`endif
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
